tc141_evtarb: RTL

Event scheduler for asynchronous strobe inputs. Each of NEV raw inputs goes through its own NPP-stage synchronizer and rising-edge detector. Every detected edge is latched as a pending event. Pending events are granted one at a time, round-robin, to a single downstream consumer over a valid/ack handshake. The block sits between off-domain status/interrupt lines and the local control FSM, so the consumer sees one event at a time.

---
 rtl/tc141_evtarb.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/tc141_evtarb.sv
// tc141_evtarb: per-source synchronizer + rising-edge detect, sticky pending
// latch, and round-robin single-consumer grant over a valid/ack handshake.
// Optional feature macro: TC141_EVTARB_OVF_EN (per-source sticky overflow flags).
module tc141_evtarb #(
    parameter int unsigned NEV = 4,
    parameter int unsigned NPP = 2,
    parameter int unsigned IDW = 2
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [NEV-1:0] din,
    input  logic           evt_ack,
    input  logic           ovf_clr,
    output logic           evt_vld,
    output logic [IDW-1:0] evt_id,
    output logic [NEV-1:0] pend,
    output logic [NEV-1:0] ovf
);

    localparam int unsigned IDXW = (NEV > 1) ? $clog2(NEV) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [NEV-1:0][NPP-1:0]  sy_q, sy_d;
    logic [NEV-1:0]           pend_q, pend_d;
    logic                     evt_vld_q, evt_vld_d;
    logic [IDW-1:0]           evt_id_q, evt_id_d;
    logic [IDW-1:0]           lastp_q, lastp_d;

    logic [NEV-1:0]           pe;
    logic [NEV-1:0]           clr_vec;
    logic                     ack_fire;
    logic                     win_found;
    logic [IDW-1:0]           win_idx;

    // Synchronizer shift (input enters at the top bit) and rising-edge pulse.
    always_comb begin
        sy_d = sy_q;
        pe   = '0;
        for (int unsigned i = 0; i < NEV; i++) begin
            sy_d[i] = {din[i], sy_q[i][NPP-1:1]};
            pe[i]   = sy_q[i][1] & ~sy_q[i][0];
        end
    end

    // Ack only counts while an event is actually presented.
    always_comb begin
        ack_fire = (state_q == S_GRANT) && evt_ack;
        clr_vec  = '0;
        for (int unsigned i = 0; i < NEV; i++) begin
            clr_vec[i] = ack_fire && (evt_id_q == IDW'(i));
        end
    end

    // Pending latch: a new edge beats a same-cycle clear so it stays queued.
    always_comb begin
        pend_d = pe | (pend_q & ~clr_vec);
    end

    // Round-robin winner: first pending index after lastp, wrapping mod NEV.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= NEV; k++) begin
            cand = (32'(lastp_q) + k) % NEV;
            if (!win_found && pend_q[IDXW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDW'(cand);
            end
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (win_found) state_d = S_GRANT;
            S_GRANT: if (evt_ack)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs (registered): valid, held index, round-robin pointer.
    always_comb begin
        evt_vld_d = 1'b0;
        evt_id_d  = evt_id_q;
        lastp_d   = lastp_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    evt_vld_d = 1'b1;
                    evt_id_d  = win_idx;
                end
            end
            S_GRANT: begin
                evt_vld_d = ~evt_ack;
                if (evt_ack) lastp_d = evt_id_q;
            end
            default: evt_vld_d = 1'b0;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            sy_q      <= '0;
            pend_q    <= '0;
            evt_vld_q <= 1'b0;
            evt_id_q  <= '0;
            lastp_q   <= IDW'(NEV - 1);
        end else begin
            state_q   <= state_d;
            sy_q      <= sy_d;
            pend_q    <= pend_d;
            evt_vld_q <= evt_vld_d;
            evt_id_q  <= evt_id_d;
            lastp_q   <= lastp_d;
        end
    end

`ifdef TC141_EVTARB_OVF_EN
    logic [NEV-1:0] ovf_q, ovf_d;

    // Overflow: edge on an already-pending source not being cleared; set beats clear.
    always_comb begin
        ovf_d = (ovf_q & ~{NEV{ovf_clr}}) | (pe & pend_q & ~clr_vec);
    end

    // Sticky overflow register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ovf_q <= '0;
        else       ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf            = '0;
`endif

    assign evt_vld = evt_vld_q;
    assign evt_id  = evt_id_q;
    assign pend    = pend_q;

endmodule
